// File: rtl/udp_tx_traffic_gen_pkg.sv
// Shared definitions for the UDP transmit traffic generator and its PRBS helper.
// Payload mode encodings, FSM states, LFSR seed and the fixed IP fragment flags.
package udp_tx_traffic_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_INC   = 2'd1,
        MODE_PRBS  = 2'd2,
        MODE_CHID  = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_START,
        ST_WAIT_BUSY,
        ST_SEND,
        ST_DRAIN,
        ST_GAP
    } state_t;

    localparam logic [7:0] LFSR_SEED  = 8'hFF;
    localparam logic       DF_DEFAULT = 1'b1;
    localparam logic       MF_DEFAULT = 1'b0;

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/udp_tx_traffic_gen_prbs8_lfsr.sv
// 8-bit PRBS generator with synchronous seed load; shared with the receive checker.
module prbs8_lfsr
    import udp_tx_traffic_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/udp_tx_traffic_gen.sv
// Multi-channel UDP traffic source driving the ethernet core transmit control port.
// Channels are served round-robin; each packet's parameters are latched at arbitration.
module udp_tx_traffic_gen
    import udp_tx_traffic_gen_pkg::*;
#(
    parameter int         NUM_CH     = 2,
    parameter int         MAX_LEN    = 1472,
    parameter logic [7:0] CONST_BYTE = 8'h66,
    parameter int         START_TMO  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [15:0]          gap_cycles,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_CH*16-1:0] ch_len,
    input  logic [NUM_CH*2-1:0]  ch_mode,
    input  logic [NUM_CH*48-1:0] ch_dst_mac,
    input  logic [NUM_CH*32-1:0] ch_dst_addr,
    input  logic [NUM_CH*16-1:0] ch_dst_port,
    input  logic                 busy_tx,
    input  logic                 dv_tx,
    output logic                 cvt_tx,
    output logic [7:0]           data_tx,
    output logic [15:0]          data_len_tx,
    output logic [47:0]          dst_mac,
    output logic [31:0]          dst_addr,
    output logic [15:0]          dst_port,
    output logic                 DF_tx,
    output logic                 MF_tx,
    output logic [2:0]           active_ch,
    output logic [31:0]          pkt_cnt,
    output logic                 err_tmo,
    output logic                 err_ovr
);

    localparam int unsigned NCH       = NUM_CH;
    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
    localparam logic [15:0] TMO_LAST  = 16'(START_TMO - 1);

    state_t      state, state_nx, exit_st;
    logic [2:0]  rr_ptr, rr_nx;
    logic [15:0] gap_cnt, byte_cnt, tmo_cnt;
    mode_t       mode_q, sel_mode;
    logic [7:0]  data_q, lfsr_q, first_byte;
    logic [NUM_CH-1:0] ok;
    logic        found;
    int unsigned sel_idx;
    logic [15:0] sel_len, len_clip, sel_port;
    logic [47:0] sel_mac;
    logic [31:0] sel_addr;
    logic        lfsr_load, lfsr_step;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ok
        assign ok[g] = ch_en[g] && (ch_len[16*g +: 16] != '0);
    end

    // Two passes give "first at or after rr_ptr, wrapping" with constant indices only.
    always_comb begin
        found    = 1'b0;
        sel_idx  = 0;
        sel_len  = '0;
        sel_mac  = '0;
        sel_addr = '0;
        sel_port = '0;
        sel_mode = MODE_CONST;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && ok[i] && i >= {29'd0, rr_ptr}) begin
                found   = 1'b1;
                sel_idx = i;
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && ok[i] && i < {29'd0, rr_ptr}) begin
                found   = 1'b1;
                sel_idx = i;
            end
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            if (sel_idx == i) begin
                sel_len  = ch_len[16*i +: 16];
                sel_mac  = ch_dst_mac[48*i +: 48];
                sel_addr = ch_dst_addr[32*i +: 32];
                sel_port = ch_dst_port[16*i +: 16];
                sel_mode = mode_t'(ch_mode[2*i +: 2]);
            end
        end
        len_clip = (sel_len > MAX_LEN16) ? MAX_LEN16 : sel_len;
        rr_nx    = (sel_idx == NCH - 1) ? 3'd0 : 3'(sel_idx + 1);
        case (sel_mode)
            MODE_CONST: first_byte = CONST_BYTE;
            MODE_CHID:  first_byte = {5'b0, 3'(sel_idx)};
            default:    first_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_nx = state;
        exit_st  = (gap_cycles == '0) ? (enable ? ST_ARB : ST_IDLE) : ST_GAP;
        case (state)
            ST_IDLE:      if (enable && (|ch_en)) state_nx = ST_ARB;
            ST_ARB:       state_nx = found ? ST_START : ST_IDLE;
            ST_START:     if (!busy_tx) state_nx = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (busy_tx)                  state_nx = ST_SEND;
                else if (tmo_cnt == TMO_LAST) state_nx = exit_st;
            end
            ST_SEND: begin
                if (!busy_tx)                                      state_nx = exit_st;
                else if (dv_tx && (byte_cnt + 16'd1 == data_len_tx)) state_nx = ST_DRAIN;
            end
            ST_DRAIN:     if (!busy_tx) state_nx = exit_st;
            ST_GAP:       if (gap_cnt == '0) state_nx = enable ? ST_ARB : ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    assign lfsr_load = (state == ST_ARB) && found;
    assign lfsr_step = (state == ST_SEND) && dv_tx && (mode_q == MODE_PRBS);

    prbs8_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (LFSR_SEED),
        .step  (lfsr_step),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            gap_cnt     <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            mode_q      <= MODE_CONST;
            data_q      <= '0;
            cvt_tx      <= 1'b0;
            data_len_tx <= '0;
            dst_mac     <= '0;
            dst_addr    <= '0;
            dst_port    <= '0;
            active_ch   <= '0;
            pkt_cnt     <= '0;
            err_tmo     <= 1'b0;
            err_ovr     <= 1'b0;
        end else begin
            state  <= state_nx;
            cvt_tx <= (state == ST_START) && !busy_tx;
            if (state != ST_GAP && state_nx == ST_GAP) begin
                gap_cnt <= gap_cycles - 16'd1;
            end
            case (state)
                ST_ARB: begin
                    if (found) begin
                        data_len_tx <= len_clip;
                        dst_mac     <= sel_mac;
                        dst_addr    <= sel_addr;
                        dst_port    <= sel_port;
                        mode_q      <= sel_mode;
                        active_ch   <= 3'(sel_idx);
                        rr_ptr      <= rr_nx;
                        data_q      <= first_byte;
                        byte_cnt    <= '0;
                    end
                end
                ST_START: tmo_cnt <= '0;
                ST_WAIT_BUSY: begin
                    if (!busy_tx && tmo_cnt == TMO_LAST) err_tmo <= 1'b1;
                    else                                 tmo_cnt <= tmo_cnt + 16'd1;
                end
                ST_SEND: begin
                    if (dv_tx) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (mode_q == MODE_INC) data_q <= data_q + 8'd1;
                    end
                    if (!busy_tx) pkt_cnt <= pkt_cnt + 32'd1;
                end
                ST_DRAIN: begin
                    if (dv_tx)    err_ovr <= 1'b1;
                    if (!busy_tx) pkt_cnt <= pkt_cnt + 32'd1;
                end
                ST_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
                default: ;
            endcase
        end
    end

    assign data_tx = (mode_q == MODE_PRBS) ? lfsr_q : data_q;
    assign DF_tx   = DF_DEFAULT;
    assign MF_tx   = MF_DEFAULT;

endmodule

// File: tb/tb_udp_tx_traffic_gen.sv
// Directed bench for udp_tx_traffic_gen with a simple ethernet-core handshake model.
module tb_udp_tx_traffic_gen;

    logic          clk, rst_n, enable;
    logic [15:0]   gap_cycles;
    logic [2:0]    ch_en;
    logic [47:0]   ch_len;
    logic [5:0]    ch_mode;
    logic [143:0]  ch_dst_mac;
    logic [95:0]   ch_dst_addr;
    logic [47:0]   ch_dst_port;
    logic          busy_tx, dv_tx;
    logic          cvt_tx, DF_tx, MF_tx, err_tmo, err_ovr;
    logic [7:0]    data_tx;
    logic [15:0]   data_len_tx, dst_port;
    logic [47:0]   dst_mac;
    logic [31:0]   dst_addr, pkt_cnt;
    logic [2:0]    active_ch;

    logic [7:0]    cap [0:1499];
    int            n_checks, n_pass;

    udp_tx_traffic_gen #(.NUM_CH(3), .MAX_LEN(1472), .CONST_BYTE(8'h66), .START_TMO(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .gap_cycles(gap_cycles),
        .ch_en(ch_en), .ch_len(ch_len), .ch_mode(ch_mode),
        .ch_dst_mac(ch_dst_mac), .ch_dst_addr(ch_dst_addr), .ch_dst_port(ch_dst_port),
        .busy_tx(busy_tx), .dv_tx(dv_tx), .cvt_tx(cvt_tx), .data_tx(data_tx),
        .data_len_tx(data_len_tx), .dst_mac(dst_mac), .dst_addr(dst_addr),
        .dst_port(dst_port), .DF_tx(DF_tx), .MF_tx(MF_tx), .active_ch(active_ch),
        .pkt_cnt(pkt_cnt), .err_tmo(err_tmo), .err_ovr(err_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [47:0] mac_of(input int ch);
        case (ch)
            0: return 48'h02AA_0000_0A00;
            1: return 48'h02AA_0000_0B11;
            default: return 48'h02AA_0000_0C22;
        endcase
    endfunction

    task automatic set_ch(input int ch, input logic [15:0] len, input logic [1:0] mode);
        ch_len[16*ch +: 16] = len;
        ch_mode[2*ch +: 2]  = mode;
    endtask

    task automatic wait_start(input int exp_ch);
        int n;
        n = 0;
        while (!cvt_tx && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 64'(cvt_tx), 64'(1));
        check("active_ch", 64'(active_ch), 64'(exp_ch));
    endtask

    task automatic serve_begin();
        busy_tx = 1'b1;
        @(negedge clk);
        check("cvt_single", 64'(cvt_tx), 64'(0));
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            cap[base + i] = data_tx;
            dv_tx = 1'b1;
            @(negedge clk);
        end
        dv_tx = 1'b0;
    endtask

    task automatic finish_pkt();
        dv_tx   = 1'b0;
        busy_tx = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        logic seen;
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; enable = 1'b0; gap_cycles = '0; ch_en = '0;
        ch_len = '0; ch_mode = '0; busy_tx = 1'b0; dv_tx = 1'b0;
        ch_dst_mac  = {mac_of(2), mac_of(1), mac_of(0)};
        ch_dst_addr = {32'hC0A8_0003, 32'hC0A8_0002, 32'hC0A8_0001};
        ch_dst_port = {16'd7002, 16'd7001, 16'd7000};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_cvt", 64'(cvt_tx), 64'(0));
        check("rst_data", 64'(data_tx), 64'(0));
        check("rst_len", 64'(data_len_tx), 64'(0));
        check("rst_df_mf", 64'({DF_tx, MF_tx}), 64'(2'b10));
        check("rst_pkt", 64'(pkt_cnt), 64'(0));
        check("rst_err", 64'({err_tmo, err_ovr}), 64'(0));

        // Single channel, incrementing payload, config change mid-packet ignored
        ch_en = 3'b001; set_ch(0, 16'd4, 2'd1); enable = 1'b1;
        wait_start(0);
        check("t1_len", 64'(data_len_tx), 64'(4));
        check("t1_mac", 64'(dst_mac), 64'(mac_of(0)));
        serve_begin();
        feed(4, 0);
        set_ch(0, 16'd9, 2'd1);
        check("t1_bytes", 64'({cap[0], cap[1], cap[2], cap[3]}), 64'(32'h00010203));
        check("t1_len_hold", 64'(data_len_tx), 64'(4));
        enable = 1'b0;
        finish_pkt();
        check("t1_pkt", 64'(pkt_cnt), 64'(1));

        // Round robin over ch0/ch2 with per-channel destinations
        do_reset();
        check("rst2_pkt", 64'(pkt_cnt), 64'(0));
        ch_en = 3'b101;
        set_ch(0, 16'd10, 2'd1); set_ch(1, 16'd20, 2'd1); set_ch(2, 16'd30, 2'd1);
        enable = 1'b1;
        wait_start(0);
        check("t2a_len", 64'(data_len_tx), 64'(10));
        check("t2a_dst", 64'({dst_addr, dst_port}), 64'({32'hC0A8_0001, 16'd7000}));
        serve_begin(); feed(10, 0); finish_pkt();
        wait_start(2);
        check("t2b_len", 64'(data_len_tx), 64'(30));
        check("t2b_mac", 64'(dst_mac), 64'(mac_of(2)));
        check("t2b_dst", 64'({dst_addr, dst_port}), 64'({32'hC0A8_0003, 16'd7002}));
        serve_begin(); feed(30, 0);
        check("t2b_last", 64'(cap[29]), 64'(8'h1D));
        finish_pkt();
        wait_start(0);
        check("t2c_mac", 64'(dst_mac), 64'(mac_of(0)));
        serve_begin(); feed(10, 0);
        enable = 1'b0;
        finish_pkt();
        check("t2_pkt", 64'(pkt_cnt), 64'(3));

        // PRBS, constant and channel-id payloads on ch1/ch2
        ch_en = 3'b010; set_ch(1, 16'd5, 2'd2); enable = 1'b1;
        wait_start(1);
        serve_begin(); feed(5, 0);
        check("t3_prbs", 64'({cap[0], cap[1], cap[2], cap[3], cap[4]}), 64'(40'hFF_FE_FC_F8_F0));
        check("t3_prbs_next", 64'(data_tx), 64'(8'hE1));
        enable = 1'b0; finish_pkt();
        set_ch(1, 16'd5, 2'd0); enable = 1'b1;
        wait_start(1);
        serve_begin(); feed(5, 0);
        check("t3_const", 64'({cap[0], cap[1], cap[2], cap[3], cap[4]}), 64'(40'h66_66_66_66_66));
        enable = 1'b0; finish_pkt();
        ch_en = 3'b100; set_ch(2, 16'd2, 2'd3); enable = 1'b1;
        wait_start(2);
        serve_begin(); feed(2, 0);
        check("t3_chid", 64'({cap[0], cap[1]}), 64'(16'h0202));
        enable = 1'b0; finish_pkt();
        check("t3_pkt", 64'(pkt_cnt), 64'(6));

        // Start timeout on ch0, then ch1 is tried
        ch_en = 3'b011; set_ch(0, 16'd3, 2'd1); set_ch(1, 16'd3, 2'd1); enable = 1'b1;
        wait_start(0);
        repeat (15) @(negedge clk);
        check("t4_tmo_early", 64'(err_tmo), 64'(0));
        @(negedge clk);
        check("t4_tmo", 64'(err_tmo), 64'(1));
        check("t4_pkt_hold", 64'(pkt_cnt), 64'(6));
        wait_start(1);
        serve_begin(); feed(3, 0);
        enable = 1'b0; finish_pkt();
        check("t4_pkt", 64'(pkt_cnt), 64'(7));

        // Length clipping and overrun
        ch_en = 3'b100; set_ch(2, 16'd2000, 2'd1); enable = 1'b1;
        wait_start(2);
        check("t5_clip", 64'(data_len_tx), 64'(1472));
        serve_begin(); feed(1472, 0);
        check("t5_wrap", 64'({cap[255], cap[256]}), 64'(16'hFF00));
        check("t5_no_ovr", 64'(err_ovr), 64'(0));
        check("t5_end_byte", 64'(data_tx), 64'(8'hC0));
        feed(3, 1472);
        check("t5_ovr", 64'(err_ovr), 64'(1));
        check("t5_frozen", 64'({cap[1474], data_tx}), 64'(16'hC0C0));
        enable = 1'b0; finish_pkt();
        check("t5_pkt", 64'(pkt_cnt), 64'(8));

        // Inter-packet gap, enable drop mid-packet, asynchronous reset
        ch_en = 3'b001; set_ch(0, 16'd4, 2'd1); gap_cycles = 16'd100; enable = 1'b1;
        wait_start(0);
        serve_begin(); feed(4, 0); finish_pkt();
        check("t6_pkt_a", 64'(pkt_cnt), 64'(9));
        cnt = 0;
        while (!cvt_tx && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("t6_gap", 64'(cnt), 64'(102));
        serve_begin(); feed(2, 0);
        enable = 1'b0;
        feed(2, 2);
        finish_pkt();
        check("t6_pkt_b", 64'(pkt_cnt), 64'(10));
        seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (cvt_tx) seen = 1'b1;
        end
        check("t6_idle", 64'(seen), 64'(0));
        enable = 1'b1;
        wait_start(0);
        serve_begin(); feed(2, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_data", 64'({data_tx, data_len_tx}), 64'(0));
        check("t6_rst_dst", 64'({dst_addr, dst_port}), 64'(0));
        check("t6_rst_mac", 64'(dst_mac), 64'(0));
        check("t6_rst_misc", 64'({cvt_tx, active_ch, err_tmo, err_ovr, DF_tx, MF_tx}), 64'(8'b0000_0010));
        check("t6_rst_pkt", 64'(pkt_cnt), 64'(0));
        busy_tx = 1'b0; dv_tx = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
